// File: rtl/dallanma_ongorucu.sv
// Direct-mapped BTB with 2-bit saturating counters: predicts taken/next PC one cycle after the fetch query.
// Trained every cycle by execute feedback (g2 outcome, g1 redirect target); no back-pressure on either side.
module dallanma_ongorucu #(
  parameter int PS_BIT  = 32,
  parameter int SATIR   = 64,
  parameter int IDX_BIT = $clog2(SATIR)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PS_BIT-1:0] ps_i,
  input  logic              ps_gecerli_i,
  input  logic              duraklat_i,
  input  logic              bosalt_i,
  output logic [PS_BIT-1:0] tahmin_ps_o,
  output logic              tahmin_atladi_o,
  output logic              tahmin_gecerli_o,
  input  logic [PS_BIT-1:0] g1_ps_i,
  input  logic              g1_ps_gecerli_i,
  input  logic [PS_BIT-1:0] g2_ps_i,
  input  logic              g2_guncelle_i,
  input  logic              g2_atladi_i
);

  localparam int TAG_BIT = PS_BIT - IDX_BIT - 2;

  typedef struct packed {
    logic               valid;
    logic [TAG_BIT-1:0] tag;
    logic [PS_BIT-1:0]  target;
    logic [1:0]         sayac;
  } satir_t;

  satir_t tablo [SATIR];

  // Query side reads the table before this cycle's update lands (read-before-write).
  logic [IDX_BIT-1:0] q_idx;
  logic [TAG_BIT-1:0] q_tag;
  satir_t             q_satir;
  logic               q_hit;
  logic               q_atladi;
  logic [PS_BIT-1:0]  q_sonraki;

  always_comb begin
    q_idx     = ps_i[IDX_BIT+1:2];
    q_tag     = ps_i[PS_BIT-1:IDX_BIT+2];
    q_satir   = tablo[q_idx];
    q_hit     = q_satir.valid && (q_satir.tag == q_tag);
    q_atladi  = q_hit && q_satir.sayac[1];
    q_sonraki = q_atladi ? q_satir.target : (ps_i + PS_BIT'(4));
  end

  logic [IDX_BIT-1:0] u_idx;
  logic [TAG_BIT-1:0] u_tag;
  satir_t             u_satir;
  satir_t             u_yeni;
  logic               u_hit;
  logic               u_yaz;

  always_comb begin
    u_idx   = g2_ps_i[IDX_BIT+1:2];
    u_tag   = g2_ps_i[PS_BIT-1:IDX_BIT+2];
    u_satir = tablo[u_idx];
    u_hit   = u_satir.valid && (u_satir.tag == u_tag);
    u_yeni  = u_satir;
    u_yaz   = 1'b0;
    if (g2_guncelle_i) begin
      if (u_hit) begin
        u_yaz = 1'b1;
        if (g2_atladi_i) begin
          if (u_satir.sayac != 2'b11) u_yeni.sayac = u_satir.sayac + 2'b01;
          if (g1_ps_gecerli_i) u_yeni.target = g1_ps_i;
        end else if (u_satir.sayac != 2'b00) begin
          u_yeni.sayac = u_satir.sayac - 2'b01;
        end
      end else if (g2_atladi_i && g1_ps_gecerli_i) begin
        // Newly seen taken branch starts weakly taken so the next fetch follows it.
        u_yaz  = 1'b1;
        u_yeni = '{valid: 1'b1, tag: u_tag, target: g1_ps_i, sayac: 2'b10};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SATIR; i++) begin
        tablo[i] <= '{valid: 1'b0, tag: '0, target: '0, sayac: 2'b01};
      end
    end else if (u_yaz) begin
      tablo[u_idx] <= u_yeni;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tahmin_ps_o      <= '0;
      tahmin_atladi_o  <= 1'b0;
      tahmin_gecerli_o <= 1'b0;
    end else if (bosalt_i) begin
      tahmin_gecerli_o <= 1'b0;
    end else if (!duraklat_i) begin
      tahmin_ps_o      <= q_sonraki;
      tahmin_atladi_o  <= q_atladi;
      tahmin_gecerli_o <= ps_gecerli_i;
    end
  end

  // Byte offset of the resolved PC never affects indexing or tagging.
  logic unused_g2_ofs;
  assign unused_g2_ofs = ^g2_ps_i[1:0];

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Directed test-plan scenarios plus randomized traffic, checked against a per-entry table model.
module tb_dallanma_ongorucu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ps;
  logic        ps_gecerli;
  logic        duraklat;
  logic        bosalt;
  logic [31:0] tahmin_ps;
  logic        tahmin_atladi;
  logic        tahmin_gecerli;
  logic [31:0] g1_ps;
  logic        g1_ps_gecerli;
  logic [31:0] g2_ps;
  logic        g2_guncelle;
  logic        g2_atladi;

  int n_test = 0;
  int n_fail = 0;

  // Reference table: one slot per index, counter kept as a plain integer 0..3.
  bit          m_valid  [64];
  logic [23:0] m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  logic        e_gecerli = 1'b0;
  logic        e_atladi  = 1'b0;
  logic [31:0] e_ps      = '0;

  always #5 clk = ~clk;

  dallanma_ongorucu #(.PS_BIT(32), .SATIR(64)) dut (
    .clk_i(clk), .rst_i(rst), .ps_i(ps), .ps_gecerli_i(ps_gecerli),
    .duraklat_i(duraklat), .bosalt_i(bosalt),
    .tahmin_ps_o(tahmin_ps), .tahmin_atladi_o(tahmin_atladi), .tahmin_gecerli_o(tahmin_gecerli),
    .g1_ps_i(g1_ps), .g1_ps_gecerli_i(g1_ps_gecerli),
    .g2_ps_i(g2_ps), .g2_guncelle_i(g2_guncelle), .g2_atladi_i(g2_atladi)
  );

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_test++;
    if (gozlenen !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic model_adim();
    int ix;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      e_gecerli = 1'b0;
      e_atladi  = 1'b0;
      e_ps      = '0;
      return;
    end
    if (bosalt) begin
      e_gecerli = 1'b0;
    end else if (!duraklat) begin
      ix = int'(ps[7:2]);
      e_gecerli = ps_gecerli;
      if (m_valid[ix] && m_tag[ix] == ps[31:8] && m_ctr[ix] >= 2) begin
        e_atladi = 1'b1;
        e_ps     = m_target[ix];
      end else begin
        e_atladi = 1'b0;
        e_ps     = ps + 32'd4;
      end
    end
    if (g2_guncelle) begin
      ix = int'(g2_ps[7:2]);
      if (m_valid[ix] && m_tag[ix] == g2_ps[31:8]) begin
        if (g2_atladi) begin
          m_ctr[ix] = (m_ctr[ix] + 1 > 3) ? 3 : m_ctr[ix] + 1;
          if (g1_ps_gecerli) m_target[ix] = g1_ps;
        end else begin
          m_ctr[ix] = (m_ctr[ix] - 1 < 0) ? 0 : m_ctr[ix] - 1;
        end
      end else if (g2_atladi && g1_ps_gecerli) begin
        m_valid[ix]  = 1'b1;
        m_tag[ix]    = g2_ps[31:8];
        m_target[ix] = g1_ps;
        m_ctr[ix]    = 2;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare 1 time unit later.
  task automatic adim(input logic r, input logic [31:0] q, input logic qv, input logic st,
                      input logic fl, input logic [31:0] g1, input logic g1v,
                      input logic [31:0] g2, input logic up, input logic tk);
    rst = r; ps = q; ps_gecerli = qv; duraklat = st; bosalt = fl;
    g1_ps = g1; g1_ps_gecerli = g1v; g2_ps = g2; g2_guncelle = up; g2_atladi = tk;
    @(posedge clk);
    model_adim();
    #1;
    kontrol("model_gecerli", {31'd0, tahmin_gecerli}, {31'd0, e_gecerli});
    if (e_gecerli) begin
      kontrol("model_atladi", {31'd0, tahmin_atladi}, {31'd0, e_atladi});
      kontrol("model_ps", tahmin_ps, e_ps);
    end
  endtask

  task automatic sifirla();
    adim(1'b1, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic sorgu(input string etiket, input logic [31:0] q,
                       input logic [31:0] bek_ps, input logic bek_atladi);
    adim(1'b0, q, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    kontrol({etiket, "_gecerli"}, {31'd0, tahmin_gecerli}, 32'd1);
    kontrol({etiket, "_atladi"}, {31'd0, tahmin_atladi}, {31'd0, bek_atladi});
    kontrol({etiket, "_ps"}, tahmin_ps, bek_ps);
  endtask

  task automatic egit(input logic [31:0] pc, input logic tk, input logic [31:0] g1, input logic g1v);
    adim(1'b0, '0, 1'b0, 1'b0, 1'b0, g1, g1v, pc, 1'b1, tk);
  endtask

  initial begin
    sifirla();
    kontrol("reset_gecerli", {31'd0, tahmin_gecerli}, 32'd0);
    kontrol("reset_ps", tahmin_ps, 32'd0);
    kontrol("reset_atladi", {31'd0, tahmin_atladi}, 32'd0);

    sorgu("cold_100", 32'h100, 32'h104, 1'b0);
    egit(32'h100, 1'b1, 32'h200, 1'b1);
    sorgu("alloc_100", 32'h100, 32'h200, 1'b1);

    egit(32'h100, 1'b0, '0, 1'b0);
    egit(32'h100, 1'b0, '0, 1'b0);
    sorgu("ctr_00", 32'h100, 32'h104, 1'b0);
    for (int i = 0; i < 3; i++) egit(32'h100, 1'b0, '0, 1'b0);
    sorgu("ctr_sat_low", 32'h100, 32'h104, 1'b0);
    egit(32'h100, 1'b1, '0, 1'b0);
    sorgu("ctr_01", 32'h100, 32'h104, 1'b0);
    egit(32'h100, 1'b1, '0, 1'b0);
    sorgu("ctr_10", 32'h100, 32'h200, 1'b1);

    sorgu("alias_miss", 32'h4100, 32'h4104, 1'b0);
    egit(32'h4100, 1'b1, 32'h300, 1'b1);
    sorgu("alias_hit", 32'h4100, 32'h300, 1'b1);
    sorgu("alias_evict", 32'h100, 32'h104, 1'b0);

    sifirla();
    adim(1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h100, 1'b1, 1'b1);
    kontrol("rbw_old_ps", tahmin_ps, 32'h104);
    sorgu("rbw_new", 32'h100, 32'h200, 1'b1);

    for (int i = 0; i < 3; i++) begin
      adim(1'b0, $urandom, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      kontrol("stall_ps", tahmin_ps, 32'h200);
      kontrol("stall_gecerli", {31'd0, tahmin_gecerli}, 32'd1);
    end
    adim(1'b0, 32'h100, 1'b1, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
    kontrol("flush_gecerli", {31'd0, tahmin_gecerli}, 32'd0);

    sifirla();
    sorgu("post_reset", 32'h100, 32'h104, 1'b0);

    // Narrow PC space so random traffic keeps hitting, aliasing and saturating entries.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] q, g2, g1;
      q  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      g2 = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      g1 = $urandom;
      adim($urandom_range(0, 99) < 2, q, $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
           g1, $urandom_range(0, 9) < 6, g2, $urandom_range(0, 9) < 6,
           $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule

// File: doc/dallanma_ongorucu.md
# dallanma_ongorucu

Fetch-side branch predictor (direct-mapped BTB with 2-bit saturating counters) that answers the fetch stage's per-PC "taken?/next PC" query one cycle after the request. It is trained by the execute stage's branch feedback: the g2 update stream (`ps`, `guncelle`, `atladi`) and the g1 redirect (correct next PC on mispredict). Its `tahmin_atladi_o` becomes the uop TAKEN bit that execute later checks.

## Interface
- PS_BIT, 32, program-counter width
- SATIR, 64, table entries; power of two, ≥2
- IDX_BIT, log2(SATIR), index width; tag width = PS_BIT-IDX_BIT-2
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- ps_i  in  PS_BIT  fetch PC to predict
- ps_gecerli_i  in  1  query valid
- duraklat_i  in  1  fetch stall: hold current prediction outputs
- bosalt_i  in  1  flush: drop pending prediction
- tahmin_ps_o  out  PS_BIT  predicted next PC
- tahmin_atladi_o  out  1  predicted taken
- tahmin_gecerli_o  out  1  prediction valid
- g1_ps_i  in  PS_BIT  execute redirect PC (correct next PC)
- g1_ps_gecerli_i  in  1  redirect valid (mispredict)
- g2_ps_i  in  PS_BIT  PC of resolved control instruction
- g2_guncelle_i  in  1  update strobe
- g2_atladi_i  in  1  actual outcome taken

## Operation
- Entry: valid (1b), tag, target (PS_BIT), counter (2b). Index = ps[IDX_BIT+1:2], tag = ps[PS_BIT-1:IDX_BIT+2]; ps[1:0] ignored.
- Lookup hit = valid && tag match. Hit && counter[1]: atladi=1, ps=target. Otherwise: atladi=0, ps=ps_i+4 (mod 2^PS_BIT).
- Update on g2_guncelle_i, entry at g2_ps_i index:
  - Hit: counter saturating +1 if atladi, -1 if not (bounds 00/11). If atladi && g1_ps_gecerli_i: target <= g1_ps_i.
  - Miss && atladi && g1_ps_gecerli_i: allocate (overwrite), valid=1, tag=g2 tag, target=g1_ps_i, counter=10.
  - Miss otherwise: no change.
- g1_ps_gecerli_i without g2_guncelle_i: ignored.
- Output register priority per cycle: rst_i > bosalt_i > duraklat_i > query.
  - bosalt_i: tahmin_gecerli_o=0 next cycle; table updates in the same cycle still apply.
  - duraklat_i: all three outputs hold; query ignored (fetch re-presents it).
  - ps_gecerli_i=0 (not stalled): tahmin_gecerli_o=0 next cycle.

## Timing
- Prediction latency 1: query at cycle t → outputs at t+1, stable until next non-stalled edge.
- Update at cycle t takes effect at edge t→t+1; a query in cycle t+1 sees it.
- Same-cycle query and update to the same index: read-before-write; the query gets pre-update contents.
- Reset: all valid=0, counters=01, tahmin_ps_o=0, tahmin_atladi_o=0, tahmin_gecerli_o=0 on the next edge. Reset asserted mid-operation discards the pending prediction and all training; updates presented during reset are ignored.
- No back-pressure on g1/g2: one update accepted every cycle.

## Test plan
- Reset, query 0x100 → t+1: gecerli=1, atladi=0, ps=0x104.
- g2 update 0x100 atladi=1 with g1 0x200 → query 0x100 gives atladi=1, ps=0x200 (counter=10).
- Counter saturation on 0x100, starting at 10:
  - Two not-taken updates → 00; query → 0x104.
  - Three more not-taken → stays 00.
  - One taken → 01; query still → 0x104.
  - Second taken → 10; query → 0x200.
- Alias: 0x100 trained to 0x200; query 0x4100 → miss, 0x4104. Taken update 0x4100 with g1 0x300 → query 0x4100 gives 0x300, query 0x100 misses (0x104).
- Same-cycle query and allocating update on 0x100 → that output is 0x104; the next-cycle query returns 0x200.
- Stall and flush:
  - Outputs valid, duraklat_i 3 cycles with changing ps_i → outputs unchanged.
  - bosalt_i → gecerli=0 next cycle.
  - rst_i after training → query 0x100 gives 0x104.
